// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter.
// Holds the FSM state encoding and the data-width / timeout defaults that the
// UART transmitter and baud-rate generator benches also pick up, plus a small
// helper that sizes the transmit-done timeout counter.
package tx_arbiter_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2000000;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StStart    = 2'd1,
      StWaitDone = 2'd2,
      StRelease  = 2'd3
   } tx_state_e;

   // The counter only has to reach limit-1; keep at least one bit.
   function automatic int unsigned counter_width(input int unsigned limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/tx_arbiter_rr.sv
// Two-way round-robin pick with a registered last-grant pointer.
//
// Ports:
//   clock    system clock
//   reset    asynchronous active-high reset; pointer favours requester 0
//   req0     requester 0 pending
//   req1     requester 1 pending
//   advance  commit the current pick to the pointer (a grant is being taken)
//   pick     one-hot winner, combinational; 00 when nobody requests
module rr_arbiter_2 (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       advance,
   output logic [1:0] pick
);

   // High when requester 1 was served last, so requester 0 wins a tie.
   logic last_q;

   always_comb begin
      pick = 2'b00;
      if (req0 && req1) begin
         pick = last_q ? 2'b01 : 2'b10;
      end else if (req0) begin
         pick = 2'b01;
      end else if (req1) begin
         pick = 2'b10;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
      end else if (advance && (pick != 2'b00)) begin
         last_q <= pick[1];
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates two byte requesters onto one UART transmitter.
// A frame runs IDLE -> START -> WAIT_DONE -> RELEASE -> IDLE. The winner's
// byte and its parity are latched at the IDLE->START edge and held until the
// next frame starts. WAIT_DONE is abandoned after TIMEOUT_CYCLES clocks.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_req0/1     requester has a byte pending (level)
//   i_data0/1    requester byte, stable while its request is high
//   o_ack0/1     one-cycle pulse in START: that requester's byte was taken
//   o_tx_start   one-cycle start pulse to the transmitter (START cycle)
//   o_tx_byte    latched byte to the transmitter
//   o_tx_parity  parity of o_tx_byte (even or odd by PARITY_ODD)
//   i_tx_done    transmitter frame finished; only looked at in WAIT_DONE
//   o_grant      one-hot owner of the current frame, 00 when idle
//   o_busy       high outside IDLE
//   o_timeout    one-cycle pulse (RELEASE cycle) when a frame timed out
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int unsigned PARITY_ODD     = 0,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_req0,
   input  logic                  i_req1,
   input  logic [DATA_WIDTH-1:0] i_data0,
   input  logic [DATA_WIDTH-1:0] i_data1,
   output logic                  o_ack0,
   output logic                  o_ack1,
   output logic                  o_tx_start,
   output logic [DATA_WIDTH-1:0] o_tx_byte,
   output logic                  o_tx_parity,
   input  logic                  i_tx_done,
   output logic [1:0]            o_grant,
   output logic                  o_busy,
   output logic                  o_timeout
);

   localparam int unsigned CntW = counter_width(TIMEOUT_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic ParityInv = (PARITY_ODD != 0);

   tx_state_e             state_q, state_d;
   logic [1:0]            grant_q, grant_d;
   logic [DATA_WIDTH-1:0] byte_q, byte_d;
   logic                  parity_q, parity_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  timeout_q, timeout_d;

   logic [1:0]            pick;
   logic [DATA_WIDTH-1:0] pick_byte;
   logic                  in_idle;

   assign in_idle   = (state_q == StIdle);
   assign pick_byte = pick[0] ? i_data0 : i_data1;

   rr_arbiter_2 u_rr (
      .clock   (i_clock),
      .reset   (i_reset),
      .req0    (i_req0),
      .req1    (i_req1),
      .advance (in_idle),
      .pick    (pick)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      byte_d    = byte_q;
      parity_d  = parity_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pick != 2'b00) begin
               state_d  = StStart;
               grant_d  = pick;
               byte_d   = pick_byte;
               parity_d = (^pick_byte) ^ ParityInv;
            end
         end
         StStart: begin
            state_d = StWaitDone;
            cnt_d   = '0;
         end
         StWaitDone: begin
            // Done has priority over a timeout landing in the same cycle.
            if (i_tx_done) begin
               state_d = StRelease;
            end else if (cnt_q == CntLast) begin
               state_d   = StRelease;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRelease: begin
            state_d = StIdle;
            grant_d = 2'b00;
         end
         default: begin
            state_d = StIdle;
            grant_d = 2'b00;
         end
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= StIdle;
         grant_q   <= 2'b00;
         byte_q    <= '0;
         parity_q  <= 1'b0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         byte_q    <= byte_d;
         parity_q  <= parity_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Strobes decode straight from registered state so reset clears them at once.
   assign o_tx_start  = (state_q == StStart);
   assign o_ack0      = o_tx_start && grant_q[0];
   assign o_ack1      = o_tx_start && grant_q[1];
   assign o_tx_byte   = byte_q;
   assign o_tx_parity = parity_q;
   assign o_grant     = grant_q;
   assign o_busy      = !in_idle;
   assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_tx_arbiter.sv
module tb_tx_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1, done;
   logic [7:0] data0, data1;

   logic       ack0, ack1, tx_start, parity, busy, timeout;
   logic [7:0] tx_byte;
   logic [1:0] grant;

   logic       o_ack0, o_ack1, o_tx_start, o_parity, o_busy, o_timeout;
   logic [7:0] o_tx_byte;
   logic [1:0] o_grant;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tx_arbiter #(.DATA_WIDTH(8), .PARITY_ODD(0), .TIMEOUT_CYCLES(16)) dut (
      .i_clock(clk), .i_reset(rst), .i_req0(req0), .i_req1(req1),
      .i_data0(data0), .i_data1(data1), .o_ack0(ack0), .o_ack1(ack1),
      .o_tx_start(tx_start), .o_tx_byte(tx_byte), .o_tx_parity(parity),
      .i_tx_done(done), .o_grant(grant), .o_busy(busy), .o_timeout(timeout)
   );

   tx_arbiter #(.DATA_WIDTH(8), .PARITY_ODD(1), .TIMEOUT_CYCLES(16)) dut_odd (
      .i_clock(clk), .i_reset(rst), .i_req0(req0), .i_req1(req1),
      .i_data0(data0), .i_data1(data1), .o_ack0(o_ack0), .o_ack1(o_ack1),
      .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte), .o_tx_parity(o_parity),
      .i_tx_done(done), .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
   );

   typedef struct {
      logic       r0;
      logic       r1;
      logic [7:0] d0;
      logic [7:0] d1;
      int         dly;
      logic [1:0] g;
      logic [7:0] b;
      logic       pe;
      logic       po;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " ack0"}, {31'd0, ack0}, 0);
      check({tag, " ack1"}, {31'd0, ack1}, 0);
      check({tag, " tx_start"}, {31'd0, tx_start}, 0);
      check({tag, " tx_byte"}, {24'd0, tx_byte}, 0);
      check({tag, " parity"}, {31'd0, parity}, 0);
      check({tag, " odd parity"}, {31'd0, o_parity}, 0);
      check({tag, " grant"}, {30'd0, grant}, 0);
      check({tag, " busy"}, {31'd0, busy}, 0);
      check({tag, " timeout"}, {31'd0, timeout}, 0);
   endtask

   // Called at the negedge inside START after the request edge.
   task automatic check_start(input string tag, input logic [1:0] g, input logic [7:0] b,
                              input logic pe, input logic po);
      check({tag, " tx_start"}, {31'd0, tx_start}, 1);
      check({tag, " ack0"}, {31'd0, ack0}, {31'd0, g[0]});
      check({tag, " ack1"}, {31'd0, ack1}, {31'd0, g[1]});
      check({tag, " grant"}, {30'd0, grant}, {30'd0, g});
      check({tag, " tx_byte"}, {24'd0, tx_byte}, {24'd0, b});
      check({tag, " parity even"}, {31'd0, parity}, {31'd0, pe});
      check({tag, " parity odd"}, {31'd0, o_parity}, {31'd0, po});
      check({tag, " busy"}, {31'd0, busy}, 1);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 8'h11, 8'h22, 0, 2'b01, 8'h11, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 1, 2'b10, 8'h22, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 8'h11, 8'h22, 2, 2'b01, 8'h11, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h07, 3, 2'b10, 8'h07, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h03, 0, 2'b10, 8'h03, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 8'hF5, 8'h00, 1, 2'b01, 8'hF5, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 1'b1, 8'h80, 8'h7F, 2, 2'b10, 8'h7F, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 8'h01, 8'hAA, 0, 2'b01, 8'h01, 1'b1, 1'b0};

      rst = 1'b1; req0 = 0; req1 = 0; done = 0; data0 = 8'h00; data1 = 8'h00;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Done pulse while idle must be ignored.
      @(negedge clk);
      done = 1'b1;
      repeat (2) @(negedge clk);
      done = 1'b0;
      check("idle done busy", {31'd0, busy}, 0);
      check("idle done tx_start", {31'd0, tx_start}, 0);
      check("idle done grant", {30'd0, grant}, 0);
      check("idle done byte", {24'd0, tx_byte}, 0);

      for (int i = 0; i < 8; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         req0 = vecs[i].r0; req1 = vecs[i].r1; data0 = vecs[i].d0; data1 = vecs[i].d1;
         @(negedge clk);
         check_start(tag, vecs[i].g, vecs[i].b, vecs[i].pe, vecs[i].po);
         req0 = 0; req1 = 0;
         @(negedge clk);
         check({tag, " wait tx_start"}, {31'd0, tx_start}, 0);
         check({tag, " wait ack"}, {30'd0, ack1, ack0}, 0);
         check({tag, " wait grant"}, {30'd0, grant}, {30'd0, vecs[i].g});
         repeat (vecs[i].dly) @(negedge clk);
         done = 1'b1;
         @(negedge clk);
         done = 1'b0;
         check({tag, " release grant"}, {30'd0, grant}, {30'd0, vecs[i].g});
         check({tag, " release busy"}, {31'd0, busy}, 1);
         check({tag, " release timeout"}, {31'd0, timeout}, 0);
         @(negedge clk);
         check({tag, " idle grant"}, {30'd0, grant}, 0);
         check({tag, " idle busy"}, {31'd0, busy}, 0);
         check({tag, " idle byte"}, {24'd0, tx_byte}, {24'd0, vecs[i].b});
         check({tag, " idle parity"}, {31'd0, parity}, {31'd0, vecs[i].pe});
      end

      // Timeout: no done, pulse in the RELEASE cycle 16 clocks after entry.
      req0 = 1; data0 = 8'h5A;
      @(negedge clk);
      check_start("tmo", 2'b01, 8'h5A, 1'b0, 1'b1);
      req0 = 0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("tmo wait%0d timeout", i), {31'd0, timeout}, 0);
         check($sformatf("tmo wait%0d busy", i), {31'd0, busy}, 1);
         @(negedge clk);
      end
      check("tmo pulse", {31'd0, timeout}, 1);
      check("tmo release grant", {30'd0, grant}, 2'b01);
      @(negedge clk);
      check("tmo pulse end", {31'd0, timeout}, 0);
      check("tmo idle grant", {30'd0, grant}, 0);
      check("tmo idle busy", {31'd0, busy}, 0);

      // Done in the last timeout cycle: done wins, no pulse.
      req1 = 1; data1 = 8'hC3;
      @(negedge clk);
      check_start("race", 2'b10, 8'hC3, 1'b0, 1'b1);
      req1 = 0;
      repeat (16) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("race timeout", {31'd0, timeout}, 0);
      check("race release busy", {31'd0, busy}, 1);
      @(negedge clk);
      check("race idle busy", {31'd0, busy}, 0);

      // Request held across a frame is a new request after one idle clock.
      req0 = 1; data0 = 8'h3C;
      @(negedge clk);
      check_start("hold1", 2'b01, 8'h3C, 1'b0, 1'b1);
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      check("hold gap tx_start", {31'd0, tx_start}, 0);
      check("hold gap busy", {31'd0, busy}, 0);
      check("hold gap grant", {30'd0, grant}, 0);
      @(negedge clk);
      check_start("hold2", 2'b01, 8'h3C, 1'b0, 1'b1);
      req0 = 0;
      @(negedge clk);
      check("hold2 wait ack0", {31'd0, ack0}, 0);

      // Reset during WAIT_DONE after requester 0 was served last.
      #2 rst = 1'b1;
      #1;
      check_all_zero("async rst");
      @(negedge clk);
      req0 = 1; req1 = 1; data0 = 8'h11; data1 = 8'h22;
      rst = 1'b0;
      @(negedge clk);
      check_start("post rst", 2'b01, 8'h11, 1'b0, 1'b1);
      req0 = 0; req1 = 0;
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("post rst timeout", {31'd0, timeout}, 0);
      @(negedge clk);
      check("post rst idle", {31'd0, busy}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of data bytes.
REQ-002 Parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-003 Parameter TIMEOUT_CYCLES, default 2000000, max clocks waited for transmit-done.
REQ-004 i_clock  in  1  system clock; all state changes on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_req0 / i_req1  in  1  requester 0/1 has a byte pending (level).
REQ-007 i_data0 / i_data1  in  DATA_WIDTH  requester 0/1 byte, stable while its req is high.
REQ-008 o_ack0 / o_ack1  out  1  one-cycle pulse: requester's byte latched.
REQ-009 o_tx_start  out  1  one-cycle start pulse to the UART transmitter's tx-signal input.
REQ-010 o_tx_byte  out  DATA_WIDTH  latched byte to the UART transmitter.
REQ-011 o_tx_parity  out  1  parity bit of o_tx_byte to the UART transmitter.
REQ-012 i_tx_done  in  1  UART transmitter done-bit (frame finished).
REQ-013 o_grant  out  2  one-hot owner of the current frame; 00 when idle.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_timeout  out  1  one-cycle pulse when a frame is abandoned on timeout.

Function
REQ-016 FSM states: IDLE, START, WAIT_DONE, RELEASE.
- IDLE -> START when any req high at the edge.
- START -> WAIT_DONE unconditionally.
- WAIT_DONE -> RELEASE on i_tx_done or on timeout.
- RELEASE -> IDLE unconditionally.
REQ-017 At the IDLE->START edge the block latches the winner's data into o_tx_byte, sets o_grant, pulses the winner's ack (high exactly the START cycle).
REQ-018 o_tx_start is high only during the START cycle: one clock after the req-sampling edge.
REQ-019 o_tx_parity = XOR of o_tx_byte when PARITY_ODD=0, XNOR when 1; registered with o_tx_byte.
REQ-020 Round-robin: if both reqs high, grant the requester not served last; after reset requester 0 has priority.
REQ-021 Single req high: granted regardless of pointer; pointer updates to the granted requester.
REQ-022 i_tx_done sampled only in WAIT_DONE; ignored in IDLE, START, RELEASE.
REQ-023 Timeout counter clears on entry to WAIT_DONE, increments each WAIT_DONE cycle; reaching TIMEOUT_CYCLES-1 without done -> RELEASE with o_timeout pulse.
REQ-024 Done and timeout in the same cycle: done wins, no o_timeout.
REQ-025 o_tx_byte and o_tx_parity hold their value from START through RELEASE and remain stable in IDLE.
REQ-026 o_grant returns to 00 on RELEASE->IDLE; the RELEASE cycle guarantees one idle clock between frames.
REQ-027 Requester dropping req after ack has no effect; req held after ack is a new request.
REQ-028 Minimum frame overhead: 3 clocks plus UART frame time.

Reset
REQ-029 i_reset high forces, immediately and independent of clock: state IDLE, all outputs 0, o_tx_byte 0, timeout counter 0, round-robin pointer to favour requester 0.
REQ-030 Reset asserted mid-frame abandons the frame without ack or timeout pulse; the UART transmitter is not reset by this block.
REQ-031 First req after reset deassertion is honoured on the first rising edge with reset low.

Structure
REQ-032 Shared package holds the FSM state encoding, DATA_WIDTH default and TIMEOUT_CYCLES default, shared with UART_TX and BR_GENERATOR benches.
REQ-033 One sub-module rr_arbiter_2: combinational two-way round-robin pick plus registered last-grant pointer.

Verification
REQ-034 Single req0, data 8'hF5 -> ack0 and o_tx_start one clock after sampling, o_tx_byte=F5, parity=0 (even), grant=01 until done.
REQ-035 req0 and req1 held high, data 8'h11/8'h22 -> grants alternate 01,10,01 across frames; first grant 01 after reset.
REQ-036 req1 with data 8'h07, PARITY_ODD=1 -> o_tx_parity=0; with 8'h03 -> 1.
REQ-037 i_tx_done never asserted, TIMEOUT_CYCLES=16 -> o_timeout pulse 16 clocks after WAIT_DONE entry, return to IDLE, grant 00.
REQ-038 Reset in WAIT_DONE -> all outputs 0 asynchronously; next req0 served with requester-0 priority.
REQ-039 i_tx_done pulse while IDLE -> no state change, no outputs toggled.
